// File: rtl/seq_detector_param.sv
// Runtime-programmable Mealy serial-pattern detector with overlap control
// and a saturating match counter.

module seq_detector_param #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1010),
  parameter int unsigned        DEF_LEN     = 4,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   fill
);

  localparam int unsigned      HIST_W    = MAX_LEN - 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] win_c;
  logic [MAX_LEN-1:0] mask_c;
  logic [LEN_W-1:0]   len_m1_c;
  logic               armed_c;
  logic               hit_c;

  // Window compare: only the low len bits of window and pattern take part.
  always_comb begin
    win_c    = {hist_q, in};
    mask_c   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (LEN_W'(i) < len_q);
    end
    len_m1_c = len_q - LEN_W'(1);
    armed_c  = (len_q != '0) && (fill_q >= len_m1_c);
    hit_c    = armed_c && (((win_c ^ pat_q) & mask_c) == '0);
    out      = in_valid & hit_c & ~cfg_load & ~reset;
  end

  // Next-state: configuration capture, history shift and fill tracking.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = HIST_W'({hist_q, in});
      if (out) begin
        // Overlap keeps the match tail as the start of the next candidate.
        fill_d = ovl_q ? len_m1_c : '0;
      end else if (len_q == '0) begin
        fill_d = '0;
      end else if (fill_q < len_m1_c) begin
        fill_d = fill_q + LEN_W'(1);
      end else begin
        fill_d = len_m1_c;
      end
    end
  end

  // Saturating match counter; clear wins over a coincident match.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: vector table plus hand-written
// corner sequences, with a scoreboard queue for the Mealy output.

module tb_seq_detector_param;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       v;
    logic       b;
    logic       clr;
    logic       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       out0, out1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [3:0] fill0, fill1;

  int          checks = 0;
  int          errors = 0;
  int unsigned cnt_m8 = 0;
  int unsigned cnt_m2 = 0;
  logic        exp_q[$];
  vec_t        vecs[$];

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in(in_bit), .cnt_clr(cnt_clr), .out(out0), .match_cnt(cnt0), .fill(fill0)
  );

  seq_detector_param #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in(in_bit), .cnt_clr(cnt_clr), .out(out1), .match_cnt(cnt1), .fill(fill1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t vb(input logic b, input logic e);
    vec_t t = '0;
    t.v = 1'b1;
    t.b = b;
    t.e = e;
    return t;
  endfunction

  function automatic vec_t vgap();
    vec_t t = '0;
    return t;
  endfunction

  function automatic vec_t vrst();
    vec_t t = '0;
    t.rst = 1'b1;
    return t;
  endfunction

  function automatic vec_t vld(input logic [7:0] p, input logic [3:0] l,
                               input logic o, input logic c);
    vec_t t = '0;
    t.ld  = 1'b1;
    t.pat = p;
    t.len = l;
    t.ovl = o;
    t.clr = c;
    return t;
  endfunction

  // One cycle: drive at negedge, check out/counters before the next posedge.
  task automatic cyc(input vec_t t);
    logic e;
    @(negedge clk);
    reset       = t.rst;
    cfg_load    = t.ld;
    cfg_pattern = t.pat;
    cfg_len     = t.len;
    cfg_overlap = t.ovl;
    in_valid    = t.v;
    in_bit      = t.b;
    cnt_clr     = t.clr;
    exp_q.push_back(t.e);
    #2;
    e = exp_q.pop_front();
    chk("out", 32'(out0), 32'(e));
    chk("out_w2", 32'(out1), 32'(e));
    chk("match_cnt", 32'(cnt0), cnt_m8);
    chk("match_cnt_w2", 32'(cnt1), cnt_m2);
    if (t.rst || t.clr) begin
      cnt_m8 = 0;
      cnt_m2 = 0;
    end else if (e) begin
      if (cnt_m8 < 255) cnt_m8++;
      if (cnt_m2 < 3) cnt_m2++;
    end
  endtask

  task automatic post_fill(input string name, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(name, 32'(fill0), 32'(exp));
  endtask

  task automatic push_byte(input logic [7:0] by, input logic last_hit);
    for (int i = 7; i >= 0; i--) begin
      vecs.push_back(vb(by[i], (i == 0) ? last_hit : 1'b0));
    end
  endtask

  initial begin
    logic [7:0] a5;
    logic [11:0] alt;
    a5  = 8'hA5;
    alt = 12'b1010_1010_1010;

    // Reset, then default 1010 overlapping
    vecs.push_back(vrst());
    vecs.push_back(vrst());
    vecs.push_back(vb(1, 0)); vecs.push_back(vb(0, 0));
    vecs.push_back(vb(1, 0)); vecs.push_back(vb(0, 1));
    vecs.push_back(vb(1, 0)); vecs.push_back(vb(0, 1));
    // Non-overlapping 1010
    vecs.push_back(vld(8'h0A, 4'd4, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(vb(((i % 2) == 0) ? 1'b1 : 1'b0, (i == 3) || (i == 7)));
    end
    // Disabled detector
    vecs.push_back(vld(8'hFF, 4'd0, 1'b1, 1'b0));
    for (int i = 0; i < 11; i++) vecs.push_back(vb((i < 8) ? 1'b1 : 1'b0, 1'b0));
    // Full-length pattern, then clamped length with overlap off
    vecs.push_back(vld(a5, 4'd8, 1'b1, 1'b0));
    push_byte(a5, 1'b1);
    vecs.push_back(vld(a5, 4'd15, 1'b0, 1'b0));
    push_byte(a5, 1'b1);
    push_byte(a5, 1'b1);
    // Saturation: five overlapping matches after a clear
    vecs.push_back(vld(8'h0A, 4'd4, 1'b1, 1'b1));
    for (int i = 11; i >= 0; i--) begin
      vecs.push_back(vb(alt[i], (i <= 8) && ((i % 2) == 0)));
    end

    foreach (vecs[k]) cyc(vecs[k]);
    post_fill("fill_after_reset_seq", 4'd3);
    chk("cnt_saturated_w2", 32'(cnt1), 32'd3);
    chk("cnt_unsaturated", 32'(cnt0), 32'd5);

    // Gaps inside a 111 pattern keep fill frozen
    cyc(vld(8'h07, 4'd3, 1'b1, 1'b0));
    cyc(vb(1, 0));
    cyc(vb(1, 0));
    cyc(vgap());
    post_fill("fill_gap1", 4'd2);
    cyc(vgap());
    post_fill("fill_gap2", 4'd2);
    cyc(vb(1, 1));
    cyc(vb(1, 1));

    // cfg_load collides with the would-be matching bit
    cyc(vld(8'h0A, 4'd4, 1'b1, 1'b0));
    cyc(vb(1, 0)); cyc(vb(0, 0)); cyc(vb(1, 0));
    begin
      vec_t t;
      t = vld(8'h0A, 4'd4, 1'b1, 1'b0);
      t.v = 1'b1;
      t.b = 1'b0;
      cyc(t);
    end
    post_fill("fill_after_load_collision", 4'd0);

    // cnt_clr on a match cycle
    cyc(vb(1, 0)); cyc(vb(0, 0)); cyc(vb(1, 0));
    begin
      vec_t t;
      t = vb(0, 1);
      t.clr = 1'b1;
      cyc(t);
    end
    cyc(vgap());

    // Reset mid-pattern restores defaults and discards history
    cyc(vld(8'h07, 4'd3, 1'b0, 1'b0));
    cyc(vb(1, 0)); cyc(vb(0, 0)); cyc(vb(1, 0));
    cyc(vrst());
    post_fill("fill_after_reset", 4'd0);
    chk("cnt_after_reset", 32'(cnt0), 32'd0);
    cyc(vb(0, 0));
    cyc(vb(1, 0)); cyc(vb(0, 0)); cyc(vb(1, 0)); cyc(vb(0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
